// File: rtl/dds_word_scheduler.sv
// dds_word_scheduler: turns frequency (MHz/kHz/Hz) and phase (x, y) requests
// into DDS tuning words through one shared restoring divider, arbitrated
// round-robin between the two requesters.
//   fre_step = ((x*1e6 + y*1e3 + z) << N) / CLK_FREQ        (low N bits)
//   pha_step = (x << (M-1)) + 2^(M-1)/y                     (mod 2^M, y=0 -> 0)
// Optional build macro DDS_SHADOW_APPLY_EN: results land in shadow registers
// and are copied to the outputs together on the 'apply' strobe.
module dds_word_scheduler #(
  parameter int unsigned N         = 32,
  parameter int unsigned M         = 12,
  parameter int unsigned FRE_WIDTH = 10,
  parameter int unsigned PHA_WIDTH = 8,
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned DIV_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fre_valid,
  output logic                 fre_ready,
  input  logic [FRE_WIDTH-1:0] fre_x,
  input  logic [FRE_WIDTH-1:0] fre_y,
  input  logic [FRE_WIDTH-1:0] fre_z,
  input  logic                 pha_valid,
  output logic                 pha_ready,
  input  logic [PHA_WIDTH-1:0] pha_x,
  input  logic [PHA_WIDTH-1:0] pha_y,
  output logic [N-1:0]         fre_step,
  output logic [M-1:0]         pha_step,
  output logic                 word_upd,
  output logic                 busy
`ifdef DDS_SHADOW_APPLY_EN
  ,
  input  logic                 apply
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_COMMIT} state_e;
  typedef enum logic {RR_FRE = 1'b0, RR_PHA = 1'b1} rr_e;

  localparam int unsigned CW = (DIV_W > 1) ? $clog2(DIV_W) : 1;

  state_e               state_q, state_d;
  rr_e                  rr_q, rr_d;
  logic                 sel_pha_q, sel_pha_d;
  logic [FRE_WIDTH-1:0] fx_q, fx_d;
  logic [FRE_WIDTH-1:0] fy_q, fy_d;
  logic [FRE_WIDTH-1:0] fz_q, fz_d;
  logic [PHA_WIDTH-1:0] px_q, px_d;
  logic [PHA_WIDTH-1:0] py_q, py_d;
  logic [DIV_W-1:0]     num_q, num_d;
  logic [DIV_W-1:0]     rem_q, rem_d;
  logic [DIV_W-1:0]     den_q, den_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0]         fre_step_q, fre_step_d;
  logic [M-1:0]         pha_step_q, pha_step_d;
  logic                 word_upd_q, word_upd_d;
`ifdef DDS_SHADOW_APPLY_EN
  logic [N-1:0]         fre_sh_q, fre_sh_d;
  logic [M-1:0]         pha_sh_q, pha_sh_d;
`endif

  logic                 grant_fre;
  logic                 grant_pha;
  logic [DIV_W-1:0]     fre_hz;
  logic [DIV_W:0]       cand;
  logic                 q_bit;
  logic [N-1:0]         fre_word;
  logic [M-1:0]         q_lo;
  logic [M-1:0]         pha_word;

  // Round-robin grant: offered only in IDLE and never while reset is held
  always_comb begin
    grant_fre = 1'b0;
    grant_pha = 1'b0;
    if (state_q == S_IDLE && !rst) begin
      if (fre_valid && (!pha_valid || rr_q == RR_FRE)) begin
        grant_fre = 1'b1;
      end else if (pha_valid) begin
        grant_pha = 1'b1;
      end
    end
  end

  assign fre_ready = grant_fre;
  assign pha_ready = grant_pha;

  // Divider datapath: operand build, one restoring step, result formatting
  always_comb begin
    fre_hz   = DIV_W'(fx_q) * DIV_W'(1_000_000)
             + DIV_W'(fy_q) * DIV_W'(1_000)
             + DIV_W'(fz_q);
    cand     = {rem_q, num_q[DIV_W-1]};
    q_bit    = (cand >= {1'b0, den_q});
    fre_word = num_q[N-1:0];
    // A zero phase divisor contributes nothing rather than the all-ones quotient
    q_lo     = (den_q == '0) ? '0 : num_q[M-1:0];
    pha_word = (M'(px_q) << (M-1)) + q_lo;
  end

  // Next-state and register-update logic for the scheduler FSM
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_pha_d  = sel_pha_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    fz_d       = fz_q;
    px_d       = px_q;
    py_d       = py_q;
    num_d      = num_q;
    rem_d      = rem_q;
    den_d      = den_q;
    cnt_d      = cnt_q;
    fre_step_d = fre_step_q;
    pha_step_d = pha_step_q;
    word_upd_d = 1'b0;
`ifdef DDS_SHADOW_APPLY_EN
    fre_sh_d   = fre_sh_q;
    pha_sh_d   = pha_sh_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_fre) begin
          sel_pha_d = 1'b0;
          fx_d      = fre_x;
          fy_d      = fre_y;
          fz_d      = fre_z;
          rr_d      = RR_PHA;
          state_d   = S_LOAD;
        end else if (grant_pha) begin
          sel_pha_d = 1'b1;
          px_d      = pha_x;
          py_d      = pha_y;
          rr_d      = RR_FRE;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (sel_pha_q) begin
          num_d = DIV_W'(1) << (M-1);
          den_d = DIV_W'(py_q);
        end else begin
          num_d = fre_hz << N;
          den_d = DIV_W'(CLK_FREQ);
        end
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end

      S_DIV: begin
        // Numerator shifts out MSB first while quotient bits shift in at the LSB
        if (q_bit) begin
          rem_d = cand[DIV_W-1:0] - den_q;
        end else begin
          rem_d = cand[DIV_W-1:0];
        end
        num_d = {num_q[DIV_W-2:0], q_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_W - 1)) begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
`ifdef DDS_SHADOW_APPLY_EN
        if (sel_pha_q) begin
          pha_sh_d = pha_word;
        end else begin
          fre_sh_d = fre_word;
        end
`else
        if (sel_pha_q) begin
          pha_step_d = pha_word;
        end else begin
          fre_step_d = fre_word;
        end
        word_upd_d = 1'b1;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

`ifdef DDS_SHADOW_APPLY_EN
    // Apply copies the shadows as they will be after this edge, so a result
    // committed in the same cycle is the one that reaches the outputs
    if (apply) begin
      fre_step_d = fre_sh_d;
      pha_step_d = pha_sh_d;
      word_upd_d = 1'b1;
    end
`endif
  end

  // State and datapath registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= RR_FRE;
      sel_pha_q  <= 1'b0;
      fx_q       <= '0;
      fy_q       <= '0;
      fz_q       <= '0;
      px_q       <= '0;
      py_q       <= '0;
      num_q      <= '0;
      rem_q      <= '0;
      den_q      <= '0;
      cnt_q      <= '0;
      fre_step_q <= '0;
      pha_step_q <= '0;
      word_upd_q <= 1'b0;
`ifdef DDS_SHADOW_APPLY_EN
      fre_sh_q   <= '0;
      pha_sh_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      sel_pha_q  <= sel_pha_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      fz_q       <= fz_d;
      px_q       <= px_d;
      py_q       <= py_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      den_q      <= den_d;
      cnt_q      <= cnt_d;
      fre_step_q <= fre_step_d;
      pha_step_q <= pha_step_d;
      word_upd_q <= word_upd_d;
`ifdef DDS_SHADOW_APPLY_EN
      fre_sh_q   <= fre_sh_d;
      pha_sh_q   <= pha_sh_d;
`endif
    end
  end

  assign fre_step = fre_step_q;
  assign pha_step = pha_step_q;
  assign word_upd = word_upd_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_word_scheduler.sv
// tb_dds_word_scheduler: directed bench for dds_word_scheduler with
// hand-computed tuning words. Build macro DDS_SHADOW_APPLY_EN selects the
// shadow/apply variant; apply is then strobed in the COMMIT cycle of each
// request so the result and word_upd timing match the direct build.
module tb_dds_word_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        fre_valid;
  logic        fre_ready;
  logic [9:0]  fre_x;
  logic [9:0]  fre_y;
  logic [9:0]  fre_z;
  logic        pha_valid;
  logic        pha_ready;
  logic [7:0]  pha_x;
  logic [7:0]  pha_y;
  logic [31:0] fre_step;
  logic [11:0] pha_step;
  logic        word_upd;
  logic        busy;
`ifdef DDS_SHADOW_APPLY_EN
  logic        apply;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_fre;
  logic [11:0] exp_pha;

  always #5 clk = ~clk;

  dds_word_scheduler #(
    .N(32), .M(12), .FRE_WIDTH(10), .PHA_WIDTH(8),
    .CLK_FREQ(50_000_000), .DIV_W(64)
  ) dut (
    .clk(clk), .rst(rst),
    .fre_valid(fre_valid), .fre_ready(fre_ready),
    .fre_x(fre_x), .fre_y(fre_y), .fre_z(fre_z),
    .pha_valid(pha_valid), .pha_ready(pha_ready),
    .pha_x(pha_x), .pha_y(pha_y),
    .fre_step(fre_step), .pha_step(pha_step),
    .word_upd(word_upd), .busy(busy)
`ifdef DDS_SHADOW_APPLY_EN
    , .apply(apply)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a ready, then steps through the accept edge.
  // which: 1 = fre, 2 = pha, 3 = both readys high, 0 = timed out.
  task automatic accept_wait(output int which);
    which = 0;
    #1;
    for (int i = 0; i < 300; i++) begin
      if (fre_ready === 1'b1 && pha_ready === 1'b1) which = 3;
      else if (fre_ready === 1'b1) which = 1;
      else if (pha_ready === 1'b1) which = 2;
      if (which != 0) break;
      tick();
    end
    if (which != 0) tick();
  endtask

  // Counts cycles from the accept edge to the word_upd pulse (bounded).
  task automatic wait_upd(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (word_upd === 1'b1) break;
`ifdef DDS_SHADOW_APPLY_EN
      apply = (n == 65);
`endif
    end
`ifdef DDS_SHADOW_APPLY_EN
    apply = 1'b0;
`endif
  endtask

  task automatic fre_req(input string tag, input int x, input int y, input int z,
                         input logic [31:0] expv);
    int which;
    int n;
    fre_x = 10'(x); fre_y = 10'(y); fre_z = 10'(z);
    fre_valid = 1'b1;
    accept_wait(which);
    fre_valid = 1'b0;
    fre_x = '1; fre_y = '1; fre_z = '1;
    check({tag, "_grant"}, 64'(which), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_upd(n);
    exp_fre = expv;
    check({tag, "_lat"}, 64'(n), 64'd66);
    check({tag, "_fre"}, 64'(fre_step), 64'(exp_fre));
    check({tag, "_pha_keep"}, 64'(pha_step), 64'(exp_pha));
    tick();
    check({tag, "_upd_end"}, 64'(word_upd), 64'd0);
  endtask

  task automatic pha_req(input string tag, input int x, input int y,
                         input logic [11:0] expv);
    int which;
    int n;
    pha_x = 8'(x); pha_y = 8'(y);
    pha_valid = 1'b1;
    accept_wait(which);
    pha_valid = 1'b0;
    pha_x = '1; pha_y = '1;
    check({tag, "_grant"}, 64'(which), 64'd2);
    wait_upd(n);
    exp_pha = expv;
    check({tag, "_lat"}, 64'(n), 64'd66);
    check({tag, "_pha"}, 64'(pha_step), 64'(exp_pha));
    check({tag, "_fre_keep"}, 64'(fre_step), 64'(exp_fre));
    tick();
    check({tag, "_upd_end"}, 64'(word_upd), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int which;
    int n;
    int pulses;

    rst = 1'b1;
    fre_valid = 1'b1; pha_valid = 1'b1;
    fre_x = '0; fre_y = '0; fre_z = '0; pha_x = '0; pha_y = '0;
`ifdef DDS_SHADOW_APPLY_EN
    apply = 1'b0;
`endif
    exp_fre = '0;
    exp_pha = '0;
    repeat (3) tick();

    check("rst_fre_step", 64'(fre_step), 64'd0);
    check("rst_pha_step", 64'(pha_step), 64'd0);
    check("rst_word_upd", 64'(word_upd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fre_ready", 64'(fre_ready), 64'd0);
    check("rst_pha_ready", 64'(pha_ready), 64'd0);

    fre_valid = 1'b0; pha_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    fre_req("f_1mhz", 1, 0, 0, 32'd85899345);
    check("f_1mhz_hex", 64'(fre_step), 64'h051EB851);
    fre_req("f_1khz", 0, 1, 0, 32'd85899);
    fre_req("f_wrap", 60, 0, 0, 32'h33333333);
    pha_req("p_x0y2", 0, 2, 12'h400);
    pha_req("p_x1y4", 1, 4, 12'hA00);
    pha_req("p_div0", 3, 0, 12'h800);

    // Reset in the middle of a divide
    fre_x = 10'd2; fre_y = '0; fre_z = '0;
    fre_valid = 1'b1;
    accept_wait(which);
    fre_valid = 1'b0;
    check("mid_grant", 64'(which), 64'd1);
    repeat (21) tick();
    check("mid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    fre_valid = 1'b1; pha_valid = 1'b1;
    #1;
    check("mid_rst_fre", 64'(fre_step), 64'd0);
    check("mid_rst_pha", 64'(pha_step), 64'd0);
    check("mid_rst_upd", 64'(word_upd), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_fready", 64'(fre_ready), 64'd0);
    check("mid_rst_pready", 64'(pha_ready), 64'd0);
    exp_fre = '0;
    exp_pha = '0;
    tick();
    tick();
    rst = 1'b0;

    // Both requesters valid after reset: fre first, then the pointer alternates
    pha_x = 8'd1; pha_y = 8'd2;
    accept_wait(which);
    check("arb1_grant", 64'(which), 64'd1);
    wait_upd(n);
    check("arb1_lat", 64'(n), 64'd66);
    check("arb1_fre", 64'(fre_step), 64'd171798691);
    check("arb1_pha_keep", 64'(pha_step), 64'd0);
    check("arb1_next_pready", 64'(pha_ready), 64'd1);
    check("arb1_next_fready", 64'(fre_ready), 64'd0);

    accept_wait(which);
    check("arb2_grant", 64'(which), 64'd2);
    fre_x = 10'd1;
    wait_upd(n);
    check("arb2_lat", 64'(n), 64'd66);
    check("arb2_pha", 64'(pha_step), 64'hC00);
    check("arb2_fre_keep", 64'(fre_step), 64'd171798691);
    check("arb2_next_fready", 64'(fre_ready), 64'd1);
    check("arb2_next_pready", 64'(pha_ready), 64'd0);

    accept_wait(which);
    fre_valid = 1'b0; pha_valid = 1'b0;
    check("arb3_grant", 64'(which), 64'd1);
    wait_upd(n);
    check("arb3_lat", 64'(n), 64'd66);
    check("arb3_fre", 64'(fre_step), 64'd85899345);
    check("arb3_pha_keep", 64'(pha_step), 64'hC00);

`ifdef DDS_SHADOW_APPLY_EN
    // Two commits land in the shadows; one apply moves both at once
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulses = 0;
    fre_x = 10'd1; fre_y = '0; fre_z = '0;
    fre_valid = 1'b1;
    accept_wait(which);
    fre_valid = 1'b0;
    check("sh_fre_grant", 64'(which), 64'd1);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (word_upd === 1'b1) pulses++;
    end
    pha_x = 8'd0; pha_y = 8'd2;
    pha_valid = 1'b1;
    accept_wait(which);
    pha_valid = 1'b0;
    check("sh_pha_grant", 64'(which), 64'd2);
    for (int i = 0; i < 70; i++) begin
      tick();
      if (word_upd === 1'b1) pulses++;
    end
    check("sh_no_upd", 64'(pulses), 64'd0);
    check("sh_fre_hold", 64'(fre_step), 64'd0);
    check("sh_pha_hold", 64'(pha_step), 64'd0);
    apply = 1'b1;
    tick();
    apply = 1'b0;
    check("sh_apply_upd", 64'(word_upd), 64'd1);
    check("sh_apply_fre", 64'(fre_step), 64'h051EB851);
    check("sh_apply_pha", 64'(pha_step), 64'h400);
    tick();
    check("sh_apply_upd_end", 64'(word_upd), 64'd0);
`else
    pulses = 0;
    check("final_busy", 64'(busy + pulses), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
